// File: rtl/fp_div.sv
// -----------------------------------------------------------------------------
// fp_div : IEEE-754 binary32 iterative divider, start/done handshake.
//
// Computes op1 / op2 in the selected rounding mode. The result is placed in
// AS_Result[31:0] and AS_Result[63:32] is always zero, so the result bus and the
// exception-flag layout match the neighbouring FP add/sub path.
//
// Sequence: IDLE -> UNPACK (1) -> ITER (7) -> ROUND (1) -> DONE (1) -> IDLE.
// ITER retires 4 quotient bits per cycle, giving 28 quotient bits in total.
// Special operands (NaN, inf, zero, reserved op_type) skip the iteration but
// keep the same latency, so done always occupies the tenth cycle after the
// accepting edge.
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-low reset
//   op1        in   32  dividend, binary32
//   op2        in   32  divisor, binary32
//   rm         in   3   000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others RNE
//   op_type    in   1   0 = divide, 1 = reserved (returns qNaN with NV)
//   start      in   1   request level, sampled only in IDLE
//   done       out  1   one-cycle pulse, outputs valid
//   AS_Result  out  64  {32'b0, binary32 quotient}
//   Flags      out  5   {NV, DZ, OF, UF, NX}
//   Denorm     out  1   result is subnormal (exp field 0, fraction != 0)
// -----------------------------------------------------------------------------
module fp_div (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [2:0]  rm,
    input  logic        op_type,
    input  logic        start,
    output logic        done,
    output logic [63:0] AS_Result,
    output logic [4:0]  Flags,
    output logic        Denorm
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ITER,
        S_ROUND,
        S_DONE
    } state_t;

    // Flag bit positions inside {NV, DZ, OF, UF, NX}.
    localparam int FL_NV = 4;
    localparam int FL_DZ = 3;
    localparam int FL_OF = 2;
    localparam int FL_UF = 1;
    localparam int FL_NX = 0;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Unpacked operand: sig has its leading one at bit 23 for every nonzero
    // finite input (subnormals are normalised with exp pushed below 1).
    typedef struct packed {
        logic              sign;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
        logic              is_snan;
        logic signed [9:0] exp;
        logic [23:0]       sig;
    } operand_t;

    function automatic operand_t unpack(input logic [31:0] x);
        operand_t    o;
        logic [7:0]  e;
        logic [22:0] f;
        logic [4:0]  lz;
        e         = x[30:23];
        f         = x[22:0];
        o.sign    = x[31];
        o.is_zero = (e == 8'h00) && (f == 23'd0);
        o.is_inf  = (e == 8'hFF) && (f == 23'd0);
        o.is_nan  = (e == 8'hFF) && (f != 23'd0);
        o.is_snan = o.is_nan && !f[22];
        // Leading-zero count of {1'b0, f}: the highest set bit wins because
        // the loop runs upward and later hits overwrite earlier ones.
        lz = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (f[i]) lz = 5'(23 - i);
        end
        if (e == 8'h00) begin
            o.sig = {1'b0, f} << lz;
            o.exp = 10'sd1 - $signed({5'd0, lz});
        end else begin
            o.sig = {1'b1, f};
            o.exp = $signed({2'b00, e});
        end
        return o;
    endfunction

    // Round-up decision for a kept value with lsb, guard and the OR of all
    // lower discarded bits.
    function automatic logic round_inc(input logic [2:0] mode, input logic sgn,
                                       input logic lsb, input logic g, input logic rs);
        logic inc;
        case (mode)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sgn & (g | rs);
            3'b011:  inc = ~sgn & (g | rs);
            3'b100:  inc = g;
            default: inc = g & (rs | lsb);
        endcase
        return inc;
    endfunction

    // ---------------------------------------------------------------- state
    state_t     state_q, state_d;
    logic [2:0] iter_cnt_q, iter_cnt_d;

    // Operation registers (latched on accept / UNPACK / ITER).
    logic [31:0]       op1_q, op2_q;
    logic [2:0]        rm_q;
    logic              op_type_q;
    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [23:0]       div_q;
    logic [24:0]       rem_q;
    logic [27:0]       quo_q;
    logic              special_q;
    logic [31:0]       spec_res_q;
    logic [4:0]        spec_flags_q;

    // Output registers.
    logic [31:0] result_q, result_d;
    logic [4:0]  flags_q, flags_d;
    logic        denorm_q, denorm_d;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            iter_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_UNPACK;
            S_UNPACK: begin
                state_d    = S_ITER;
                iter_cnt_d = 3'd0;
            end
            S_ITER: begin
                if (iter_cnt_q == 3'd6) state_d = S_ROUND;
                else                    iter_cnt_d = iter_cnt_q + 3'd1;
            end
            S_ROUND:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // --------------------------------------------------------------- UNPACK
    operand_t    a_op, b_op;
    logic        spec_hit;
    logic [31:0] spec_res;
    logic [4:0]  spec_flags;
    logic        res_sign;

    always_comb begin
        a_op       = unpack(op1_q);
        b_op       = unpack(op2_q);
        res_sign   = a_op.sign ^ b_op.sign;
        spec_hit   = 1'b1;
        spec_res   = QNAN;
        spec_flags = 5'd0;
        if (op_type_q) begin
            spec_flags[FL_NV] = 1'b1;
        end else if (a_op.is_nan || b_op.is_nan) begin
            spec_flags[FL_NV] = a_op.is_snan || b_op.is_snan;
        end else if ((a_op.is_zero && b_op.is_zero) || (a_op.is_inf && b_op.is_inf)) begin
            spec_flags[FL_NV] = 1'b1;
        end else if (a_op.is_inf) begin
            spec_res = {res_sign, 8'hFF, 23'd0};
        end else if (b_op.is_inf) begin
            spec_res = {res_sign, 31'd0};
        end else if (b_op.is_zero) begin
            spec_res          = {res_sign, 8'hFF, 23'd0};
            spec_flags[FL_DZ] = 1'b1;
        end else if (a_op.is_zero) begin
            spec_res = {res_sign, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // ----------------------------------------------------------------- ITER
    // Four restoring steps per cycle. The partial remainder stays below twice
    // the divisor, so 25 bits hold it; the first bit produced is the integer
    // bit of a quotient in (0.5, 2).
    logic [24:0] rem_n;
    logic [27:0] quo_n;
    logic [25:0] diff;

    always_comb begin
        // NOTE: blocking assignments are deliberate here: each unrolled step
        // must see the remainder produced by the step before it.
        rem_n = rem_q;
        quo_n = quo_q;
        diff  = 26'd0;
        for (int k = 0; k < 4; k++) begin
            diff = {1'b0, rem_n} - {2'b00, div_q};
            if (!diff[25]) begin
                rem_n = diff[24:0];
                quo_n = {quo_n[26:0], 1'b1};
            end else begin
                quo_n = {quo_n[26:0], 1'b0};
            end
            rem_n = rem_n << 1;
        end
    end

    // ---------------------------------------------------------------- ROUND
    logic              sticky_rem;
    logic [23:0]       m_n, m_sel;
    logic              g_n, rs_n, g_sel, rs_sel;
    logic signed [9:0] e_norm, e_fin;
    logic              inc_unb, inc, tiny, inexact, lost;
    logic [9:0]        sh_amt;
    logic [25:0]       x_pre, x_sh;
    logic [24:0]       m_rnd;
    logic [31:0]       ovf_res, rnd_res;
    logic [4:0]        rnd_flags;

    always_comb begin
        sticky_rem = (rem_q != 25'd0);
        // Normalise: a quotient below 1 is shifted up one place.
        if (quo_q[27]) begin
            m_n    = quo_q[27:4];
            g_n    = quo_q[3];
            rs_n   = (|quo_q[2:0]) | sticky_rem;
            e_norm = exp_q;
        end else begin
            m_n    = quo_q[26:3];
            g_n    = quo_q[2];
            rs_n   = (|quo_q[1:0]) | sticky_rem;
            e_norm = exp_q - 10'sd1;
        end

        // Tininess is judged after rounding with an unbounded exponent: a
        // value just below the normal range that rounds up to 2^-126 is not tiny.
        inc_unb = round_inc(rm_q, sign_q, m_n[0], g_n, rs_n);
        tiny    = (e_norm < 10'sd1) && !((e_norm == 10'sd0) && (&m_n) && inc_unb);

        // Tiny results are shifted into the subnormal grid, folding every
        // bit shifted out into the sticky bit.
        sh_amt = 10'sd1 - e_norm;
        x_pre  = {m_n, g_n, rs_n};
        x_sh   = 26'd0;
        lost   = 1'b0;
        if (e_norm < 10'sd1) begin
            if (sh_amt >= 10'd26) begin
                x_sh = 26'd0;
                lost = |x_pre;
            end else begin
                x_sh = x_pre >> sh_amt;
                lost = ((x_sh << sh_amt) != x_pre);
            end
            m_sel  = x_sh[25:2];
            g_sel  = x_sh[1];
            rs_sel = x_sh[0] | lost;
        end else begin
            m_sel  = m_n;
            g_sel  = g_n;
            rs_sel = rs_n;
        end

        inc     = round_inc(rm_q, sign_q, m_sel[0], g_sel, rs_sel);
        m_rnd   = {1'b0, m_sel} + {24'd0, inc};
        inexact = g_sel | rs_sel;
        e_fin   = e_norm + $signed({9'd0, m_rnd[24]});

        case (rm_q)
            3'b001:  ovf_res = {sign_q, 31'h7F7F_FFFF};
            3'b010:  ovf_res = sign_q ? {1'b1, 31'h7F80_0000} : {1'b0, 31'h7F7F_FFFF};
            3'b011:  ovf_res = sign_q ? {1'b1, 31'h7F7F_FFFF} : {1'b0, 31'h7F80_0000};
            default: ovf_res = {sign_q, 31'h7F80_0000};
        endcase

        rnd_flags = 5'd0;
        if (e_norm < 10'sd1) begin
            // A carry into bit 23 turns the subnormal into the smallest normal.
            rnd_res = {sign_q, 7'd0, m_rnd[23], m_rnd[22:0]};
        end else if (e_fin >= 10'sd255) begin
            rnd_res           = ovf_res;
            rnd_flags[FL_OF]  = 1'b1;
            rnd_flags[FL_NX]  = 1'b1;
        end else begin
            rnd_res = {sign_q, e_fin[7:0], (m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0])};
        end
        rnd_flags[FL_NX] = rnd_flags[FL_NX] | inexact;
        rnd_flags[FL_UF] = tiny & inexact;

        result_d = special_q ? spec_res_q   : rnd_res;
        flags_d  = special_q ? spec_flags_q : rnd_flags;
        denorm_d = (result_d[30:23] == 8'h00) && (result_d[22:0] != 23'd0);
    end

    // ------------------------------------------------------------- datapath
    // NOTE: the operation registers carry no reset; the FSM reset alone
    // guarantees they are reloaded in UNPACK before anything reads them.
    always_ff @(posedge clk) begin
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op1_q     <= op1;
                    op2_q     <= op2;
                    rm_q      <= rm;
                    op_type_q <= op_type;
                end
            end
            S_UNPACK: begin
                sign_q       <= res_sign;
                exp_q        <= $signed(a_op.exp) - $signed(b_op.exp) + 10'sd127;
                div_q        <= b_op.sig;
                rem_q        <= {1'b0, a_op.sig};
                quo_q        <= 28'd0;
                special_q    <= spec_hit;
                spec_res_q   <= spec_res;
                spec_flags_q <= spec_flags;
            end
            S_ITER: begin
                if (!special_q) begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                end
            end
            default: ;
        endcase
    end

    // Outputs are captured at the end of ROUND and hold until the next
    // operation reaches ROUND.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q <= 32'd0;
            flags_q  <= 5'd0;
            denorm_q <= 1'b0;
        end else if (state_q == S_ROUND) begin
            result_q <= result_d;
            flags_q  <= flags_d;
            denorm_q <= denorm_d;
        end
    end

    assign done      = (state_q == S_DONE);
    assign AS_Result = {32'd0, result_q};
    assign Flags     = flags_q;
    assign Denorm    = denorm_q;

endmodule

// File: tb/tb_fp_div.sv
// -----------------------------------------------------------------------------
// tb_fp_div : self-checking bench for fp_div.
// Directed cases, handshake timing, mid-operation reset, then randomized
// operands checked against an exact-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fp_div;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        clk;
    logic        reset;
    logic [31:0] op1, op2;
    logic [2:0]  rm;
    logic        op_type;
    logic        start;
    logic        done;
    logic [63:0] AS_Result;
    logic [4:0]  Flags;
    logic        Denorm;

    int n_pass  = 0;
    int n_total = 0;

    fp_div dut (
        .clk       (clk),
        .reset     (reset),
        .op1       (op1),
        .op2       (op2),
        .rm        (rm),
        .op_type   (op_type),
        .start     (start),
        .done      (done),
        .AS_Result (AS_Result),
        .Flags     (Flags),
        .Denorm    (Denorm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Round an integer q (plus a sticky below it) by dropping sh low bits.
    task automatic round_at(input longint unsigned q, input bit st, input int sh,
                            input bit sg, input logic [2:0] mode,
                            output longint unsigned kept, output bit inx);
        bit g, rest, up;
        if (sh > 60) begin
            kept = 0;
            g    = 1'b0;
            rest = (q != 0) || st;
        end else begin
            kept = q >> sh;
            g    = q[sh-1];
            rest = ((q & ((64'd1 << (sh - 1)) - 64'd1)) != 0) || st;
        end
        case (mode)
            3'b001:  up = 1'b0;
            3'b010:  up = sg && (g || rest);
            3'b011:  up = !sg && (g || rest);
            3'b100:  up = g;
            default: up = g && (rest || kept[0]);
        endcase
        kept = kept + (up ? 64'd1 : 64'd0);
        inx  = g || rest;
    endtask

    // Reference: value = M * 2^E per operand, exact integer quotient with 38
    // extra bits, then rounding onto the binary32 grid.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic [2:0] mode,
                           input logic t, output logic [31:0] res, output logic [4:0] fl);
        bit a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, s, st, inx, tiny;
        longint unsigned ma, mb, q, kept, kept_u;
        int ea, eb, e, p, be, sh, lsb_exp;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_snan = a_nan && !a[22];
        b_snan = b_nan && !b[22];
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        a_zero = (a[30:0] == 0);
        b_zero = (b[30:0] == 0);
        s      = a[31] ^ b[31];
        res    = 32'd0;
        fl     = 5'd0;
        if (t) begin
            res = QNAN; fl = 5'b10000;
        end else if (a_nan || b_nan) begin
            res = QNAN; fl = {a_snan || b_snan, 4'b0000};
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            res = QNAN; fl = 5'b10000;
        end else if (a_inf) begin
            res = {s, 8'hFF, 23'd0};
        end else if (b_inf) begin
            res = {s, 31'd0};
        end else if (b_zero) begin
            res = {s, 8'hFF, 23'd0}; fl = 5'b01000;
        end else if (a_zero) begin
            res = {s, 31'd0};
        end else begin
            ma = (a[30:23] == 0) ? {41'd0, a[22:0]} : {40'd0, 1'b1, a[22:0]};
            mb = (b[30:23] == 0) ? {41'd0, b[22:0]} : {40'd0, 1'b1, b[22:0]};
            ea = ((a[30:23] == 0) ? 1 : int'(a[30:23])) - 150;
            eb = ((b[30:23] == 0) ? 1 : int'(b[30:23])) - 150;
            while (ma < (64'd1 << 23)) begin ma = ma << 1; ea--; end
            while (mb < (64'd1 << 23)) begin mb = mb << 1; eb--; end
            q  = (ma << 38) / mb;
            st = (((ma << 38) % mb) != 0);
            e  = ea - eb - 38;
            p  = 0;
            for (int i = 0; i < 64; i++) if (q[i]) p = i;
            be = p + e + 127;
            tiny = 1'b0;
            if (be < 1) begin
                round_at(q, st, p - 23, s, mode, kept_u, inx);
                tiny = !(be == 0 && kept_u == (64'd1 << 24));
            end
            sh = (be >= 1) ? (p - 23) : (-149 - e);
            round_at(q, st, sh, s, mode, kept, inx);
            lsb_exp = e + sh;
            if (kept == (64'd1 << 24)) begin kept = kept >> 1; lsb_exp++; end
            if (kept >= (64'd1 << 23) && lsb_exp + 150 >= 255) begin
                case (mode)
                    3'b001:  res = {s, 31'h7F7F_FFFF};
                    3'b010:  res = s ? 32'hFF80_0000 : 32'h7F7F_FFFF;
                    3'b011:  res = s ? 32'hFF7F_FFFF : 32'h7F80_0000;
                    default: res = {s, 31'h7F80_0000};
                endcase
                fl = 5'b00101;
            end else begin
                if (kept >= (64'd1 << 23)) res = {s, 8'(lsb_exp + 150), kept[22:0]};
                else                       res = {s, 8'h00, kept[22:0]};
                fl = {3'b000, tiny && inx, inx};
            end
        end
    endtask

    // One complete operation: accept, scramble inputs, measure latency, check.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] mode, input logic t,
                          input logic [31:0] exp_res, input logic [4:0] exp_fl);
        int lat;
        @(negedge clk);
        op1 = a; op2 = b; rm = mode; op_type = t; start = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 16 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                op1 = ~a; op2 = ~b; rm = ~mode; op_type = ~t;
            end
            if (done) lat = k;
        end
        check($sformatf("%s latency", tag), 64'(lat), 64'd10);
        check($sformatf("%s result %h/%h rm=%0d", tag, a, b, mode), AS_Result, {32'd0, exp_res});
        check($sformatf("%s flags", tag), 64'(Flags), 64'(exp_fl));
        check($sformatf("%s denorm", tag), 64'(Denorm),
              64'((exp_res[30:23] == 8'h00) && (exp_res[22:0] != 23'd0)));
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(15, 0))
            0:       x[30:23] = 8'h00;
            1:       x[30:0]  = 31'd0;
            2:       x[30:23] = 8'hFF;
            3:       x[30:0]  = 31'h7F80_0000;
            4, 5:    x[30:23] = 8'($urandom_range(12, 1));
            6, 7:    x[30:23] = 8'($urandom_range(254, 240));
            8:       x[22:0]  = 23'h7F_FFFF;
            default: x[30:23] = 8'($urandom_range(160, 96));
        endcase
        return x;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b, er;
        logic [4:0]  ef;
        logic [2:0]  m;
        logic        t;
        int          seen, first;

        reset = 1'b0; start = 1'b0; op1 = 32'd0; op2 = 32'd0; rm = 3'd0; op_type = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset done", 64'(done), 64'd0);
        check("reset result", AS_Result, 64'd0);
        check("reset flags", 64'(Flags), 64'd0);
        check("reset denorm", 64'(Denorm), 64'd0);
        reset = 1'b1;

        run_op("half",      32'h3F80_0000, 32'h4000_0000, 3'd0, 1'b0, 32'h3F00_0000, 5'b00000);
        run_op("third rne", 32'h3F80_0000, 32'h4040_0000, 3'd0, 1'b0, 32'h3EAA_AAAB, 5'b00001);
        run_op("third rtz", 32'h3F80_0000, 32'h4040_0000, 3'd1, 1'b0, 32'h3EAA_AAAA, 5'b00001);
        run_op("div zero",  32'h3F80_0000, 32'h0000_0000, 3'd0, 1'b0, 32'h7F80_0000, 5'b01000);
        run_op("zero/zero", 32'h0000_0000, 32'h0000_0000, 3'd0, 1'b0, 32'h7FC0_0000, 5'b10000);
        run_op("ovf rne",   32'h7F7F_FFFF, 32'h3F00_0000, 3'd0, 1'b0, 32'h7F80_0000, 5'b00101);
        run_op("ovf rtz",   32'h7F7F_FFFF, 32'h3F00_0000, 3'd1, 1'b0, 32'h7F7F_FFFF, 5'b00101);
        run_op("ovf rdn+",  32'h7F7F_FFFF, 32'h3F00_0000, 3'd2, 1'b0, 32'h7F7F_FFFF, 5'b00101);
        run_op("ovf rdn-",  32'hFF7F_FFFF, 32'h3F00_0000, 3'd2, 1'b0, 32'hFF80_0000, 5'b00101);
        run_op("ovf rup-",  32'hFF7F_FFFF, 32'h3F00_0000, 3'd3, 1'b0, 32'hFF7F_FFFF, 5'b00101);
        run_op("denorm",    32'h0080_0000, 32'h4000_0000, 3'd0, 1'b0, 32'h0040_0000, 5'b00000);
        run_op("uf tie",    32'h0000_0003, 32'h4000_0000, 3'd0, 1'b0, 32'h0000_0002, 5'b00011);
        run_op("snan",      32'h7F80_0001, 32'h3F80_0000, 3'd0, 1'b0, QNAN,          5'b10000);
        run_op("qnan",      32'h7FC0_0001, 32'h3F80_0000, 3'd0, 1'b0, QNAN,          5'b00000);
        run_op("inf/fin",   32'hFF80_0000, 32'h4000_0000, 3'd0, 1'b0, 32'h7F80_0000 | 32'h8000_0000, 5'b00000);
        run_op("fin/inf",   32'h4000_0000, 32'hFF80_0000, 3'd0, 1'b0, 32'h8000_0000, 5'b00000);
        run_op("reserved",  32'h3F80_0000, 32'h4000_0000, 3'd0, 1'b1, QNAN,          5'b10000);

        // Reset during the fourth ITER cycle: no done, outputs cleared.
        @(negedge clk);
        op1 = 32'h3F80_0000; op2 = 32'h4040_0000; rm = 3'd0; op_type = 1'b0; start = 1'b1;
        @(posedge clk);
        seen = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) seen++;
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midreset result", AS_Result, 64'd0);
        check("midreset flags", 64'(Flags), 64'd0);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("midreset no done", 64'(seen), 64'd0);
        run_op("after reset", 32'h3F80_0000, 32'h4040_0000, 3'd0, 1'b0, 32'h3EAA_AAAB, 5'b00001);

        // start held for two cycles: exactly one done, outputs hold afterwards.
        @(negedge clk);
        op1 = 32'h3F80_0000; op2 = 32'h4000_0000; rm = 3'd0; op_type = 1'b0; start = 1'b1;
        @(posedge clk);
        seen = 0; first = -1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 2) start = 1'b0;
            if (done) begin
                seen++;
                if (first < 0) first = k;
            end
        end
        check("hold pulses", 64'(seen), 64'd1);
        check("hold latency", 64'(first), 64'd10);
        check("hold result", AS_Result, {32'd0, 32'h3F00_0000});

        for (int n = 0; n < 200; n++) begin
            a = rand_fp();
            b = rand_fp();
            m = 3'($urandom_range(7, 0));
            t = ($urandom_range(15, 0) == 0);
            ref_div(a, b, m, t, er, ef);
            run_op($sformatf("rand%0d", n), a, b, m, t, er, ef);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
